// File: rtl/down_counter_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : down_counter_timer                                         |
// | Description : Loadable down-counting timer with prescaler. Decrements    |
// |               once per prescaled tick while running and pulses expired   |
// |               for one cycle at terminal count.                           |
// |               Build option DOWN_COUNTER_TIMER_AUTO_RELOAD_EN: when        |
// |               defined, terminal count reloads and keeps running           |
// |               (periodic timer); when undefined, it stops in DONE          |
// |               (one-shot timer).                                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module down_counter_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] counter,
   output logic             running,
   output logic             zero,
   output logic             expired
);

   // Prescaler needs at least one bit even when PRESCALE is 1.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]    C_PRESC_MAX = PW'(PRESCALE - 1);
   localparam logic [WIDTH-1:0] C_ONE       = WIDTH'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q,   state_d;
   logic [WIDTH-1:0] counter_q, counter_d;
   logic [WIDTH-1:0] reload_q,  reload_d;
   logic [PW-1:0]    presc_q,   presc_d;
   logic             expired_q, expired_d;

   // State register; async active-low reset puts every output at its rest value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         counter_q <= '0;
         reload_q  <= '0;
         presc_q   <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         reload_q  <= reload_d;
         presc_q   <= presc_d;
         expired_q <= expired_d;
      end
   end

   // Command decode (load > stop > start > tick) and countdown next-state.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      reload_d  = reload_q;
      presc_d   = presc_q;
      expired_d = 1'b0;

      if (load) begin
         counter_d = load_value;
         reload_d  = load_value;
         presc_d   = '0;
         state_d   = ST_IDLE;
      end else if (stop) begin
         // Only meaningful while running; otherwise it just swallows start.
         if (state_q == ST_RUN) begin
            state_d = ST_IDLE;
            presc_d = '0;
         end
      end else if (start && (state_q == ST_IDLE)) begin
         if (counter_q != '0) begin
            state_d = ST_RUN;
            presc_d = '0;
         end
      end else if (start && (state_q == ST_DONE)) begin
         if (reload_q != '0) begin
            counter_d = reload_q;
            state_d   = ST_RUN;
            presc_d   = '0;
         end
      end else if (state_q == ST_RUN) begin
         // start while running is a no-op, so the tick path still applies.
         if (presc_q == C_PRESC_MAX) begin
            presc_d = '0;
            if (counter_q > C_ONE) begin
               counter_d = counter_q - C_ONE;
            end else begin
               expired_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
               counter_d = reload_q;
`else
               counter_d = '0;
               state_d   = ST_DONE;
`endif
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   // Outputs straight from registers, zero decoded from the count.
   always_comb begin
      counter = counter_q;
      running = (state_q == ST_RUN);
      zero    = (counter_q == '0);
      expired = expired_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_down_counter_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_down_counter_timer                                      |
// | Description : Self-checking bench for down_counter_timer. Two instances   |
// |               (PRESCALE 1 and 3) share stimulus and are compared every    |
// |               cycle against a behavioural timer model.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_down_counter_timer;

   logic       clk;
   logic       reset;
   logic       load;
   logic [3:0] load_value;
   logic       start;
   logic       stop;

   logic [3:0] cnt_a, cnt_b;
   logic       run_a, run_b, zero_a, zero_b, exp_a, exp_b;

   int checks   = 0;
   int failures = 0;

   down_counter_timer #(.WIDTH(4), .PRESCALE(1)) dut_a (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .start(start), .stop(stop), .counter(cnt_a), .running(run_a),
      .zero(zero_a), .expired(exp_a));

   down_counter_timer #(.WIDTH(4), .PRESCALE(3)) dut_b (
      .clk(clk), .reset(reset), .load(load), .load_value(load_value),
      .start(start), .stop(stop), .counter(cnt_b), .running(run_b),
      .zero(zero_b), .expired(exp_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: index 0 is PRESCALE=1, index 1 is PRESCALE=3.
   int pre    [2] = '{1, 3};
   int m_cnt  [2];
   int m_rel  [2];
   int m_run  [2];   // 1 while counting
   int m_fin  [2];   // 1 after a one-shot has finished
   int m_elap [2];   // enabled cycles since the last tick
   int m_exp  [2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_cnt[i] = 0; m_rel[i] = 0; m_run[i] = 0;
         m_fin[i] = 0; m_elap[i] = 0; m_exp[i] = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         m_exp[i] = 0;
         if (load) begin
            m_cnt[i] = int'(load_value); m_rel[i] = int'(load_value);
            m_run[i] = 0; m_fin[i] = 0; m_elap[i] = 0;
         end else if (stop) begin
            if (m_run[i] == 1) begin
               m_run[i] = 0; m_elap[i] = 0;
            end
         end else if (start && m_run[i] == 0 && m_fin[i] == 0) begin
            if (m_cnt[i] != 0) begin
               m_run[i] = 1; m_elap[i] = 0;
            end
         end else if (start && m_fin[i] == 1) begin
            if (m_rel[i] != 0) begin
               m_cnt[i] = m_rel[i]; m_fin[i] = 0; m_run[i] = 1; m_elap[i] = 0;
            end
         end else if (m_run[i] == 1) begin
            m_elap[i] = m_elap[i] + 1;
            if (m_elap[i] == pre[i]) begin
               m_elap[i] = 0;
               if (m_cnt[i] > 1) begin
                  m_cnt[i] = m_cnt[i] - 1;
               end else begin
                  m_exp[i] = 1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                  m_cnt[i] = m_rel[i];
`else
                  m_cnt[i] = 0; m_run[i] = 0; m_fin[i] = 1;
`endif
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic check_all();
      chk("p1_counter", 32'(cnt_a),  32'(m_cnt[0]));
      chk("p1_running", 32'(run_a),  32'(m_run[0]));
      chk("p1_zero",    32'(zero_a), 32'(m_cnt[0] == 0));
      chk("p1_expired", 32'(exp_a),  32'(m_exp[0]));
      chk("p3_counter", 32'(cnt_b),  32'(m_cnt[1]));
      chk("p3_running", 32'(run_b),  32'(m_run[1]));
      chk("p3_zero",    32'(zero_b), 32'(m_cnt[1] == 0));
      chk("p3_expired", 32'(exp_b),  32'(m_exp[1]));
   endtask

   // Called at a falling edge: drive, advance model, clock, then compare.
   task automatic cycle(input bit l, input bit sp, input bit st, input logic [3:0] v);
      load = l; stop = sp; start = st; load_value = v;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      load = 1'b0; stop = 1'b0; start = 1'b0; load_value = 4'd0;
      reset = 1'b0;
      model_reset();
      @(negedge clk); @(negedge clk);
      chk("rst_counter", 32'(cnt_a), 32'd0);
      chk("rst_running", 32'(run_a), 32'd0);
      chk("rst_zero",    32'(zero_a), 32'd1);
      chk("rst_expired", 32'(exp_b), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      // One-shot / periodic run from 5, then restart without load.
      cycle(1'b1, 1'b0, 1'b0, 4'd5);
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      idle(18);
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      idle(18);

      // Prescale path with 2.
      cycle(1'b1, 1'b0, 1'b0, 4'd2);
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      idle(8);

      // Stop at 3 (PRESCALE=1 instance), hold, resume.
      cycle(1'b1, 1'b0, 1'b0, 4'd5);
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      idle(2);
      chk("stop_at3", 32'(cnt_a), 32'd3);
      cycle(1'b0, 1'b1, 1'b0, 4'd0);
      idle(10);
      chk("hold3", 32'(cnt_a), 32'd3);
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      idle(4);

      // Simultaneous load+stop+start: load wins, stays idle.
      cycle(1'b1, 1'b1, 1'b1, 4'd9);
      chk("prio_counter", 32'(cnt_a), 32'd9);
      chk("prio_running", 32'(run_b), 32'd0);
      idle(2);

      // Boundaries: zero load cannot start; 15 counts down without wrap.
      cycle(1'b1, 1'b0, 1'b0, 4'd0);
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      idle(3);
      cycle(1'b1, 1'b0, 1'b0, 4'd15);
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      idle(50);

      // Asynchronous reset in mid-run with count 7.
      cycle(1'b1, 1'b0, 1'b0, 4'd7);
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      chk("arst_counter_p3", 32'(cnt_b), 32'd0);
      chk("arst_counter_p1", 32'(cnt_a), 32'd0);
      chk("arst_running",    32'(run_b), 32'd0);
      chk("arst_zero",       32'(zero_b), 32'd1);
      chk("arst_expired",    32'(exp_a), 32'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      cycle(1'b0, 1'b0, 1'b1, 4'd0);
      idle(3);

      // Randomized command mix.
      for (int k = 0; k < 800; k++) begin
         cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/down_counter_timer.md
# down_counter_timer

Loadable down-counting timer, the countdown counterpart to the team's free-running up counter. It is loaded with a start value, decrements once per prescaled tick while running, and flags terminal count with a one-cycle `expired` pulse. It sits beside the up counter in the timing/control fabric and provides timeouts and delays to control logic.

## Interface

Parameters:
- `WIDTH`, default 4: counter and load-value width; legal range 2..16.
- `PRESCALE`, default 1: enabled clock cycles per decrement; legal range 1..256.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset; 0 clears all state immediately.
- `load`, in, 1: write `load_value` into the counter and the reload register.
- `load_value`, in, WIDTH: value captured on `load`.
- `start`, in, 1: begin or resume counting.
- `stop`, in, 1: pause counting and hold the counter.
- `counter`, out, WIDTH: current count, registered.
- `running`, out, 1: high while the FSM is in RUN.
- `zero`, out, 1: combinational, `counter == 0`.
- `expired`, out, 1: registered one-cycle pulse on reaching terminal count.

## Operation

- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- Reset values:
  - `counter` = 0, reload register = 0, prescaler = 0
  - `running` = 0, `expired` = 0, `zero` = 1
- Command priority per cycle: `load` > `stop` > `start` > tick.
- `load`, in any state:
  - `counter` and reload register take `load_value`.
  - Prescaler clears; next state is IDLE.
  - `expired` is 0 that cycle.
- `stop`: RUN goes to IDLE with `counter` held and the prescaler cleared. In IDLE or DONE, `stop` is a no-op.
- `start`:
  - In IDLE with `counter != 0`: go to RUN, prescaler cleared.
  - In IDLE with `counter == 0`: ignored.
  - In DONE: if reload register != 0, `counter` takes the reload value and the FSM goes to RUN. Otherwise it is ignored.
  - In RUN: no-op; the prescaler is not cleared.
- Prescaler:
  - Counts 0..PRESCALE-1 only in RUN.
  - A tick occurs in the cycle the prescaler equals PRESCALE-1, after which it wraps to 0.
  - With PRESCALE=1, every RUN cycle is a tick.
- Tick in RUN with `counter > 1`: `counter` decrements by 1.
- Tick in RUN with `counter == 1` is terminal. The response depends on the configuration macro (see Configuration); `expired` is 1 in the following cycle for exactly one cycle.
- Arithmetic is unsigned WIDTH bits. The counter never decrements below 0 and never wraps to all-ones.

## Timing

- `load` sampled at edge N: `counter` = `load_value` after edge N.
- `start` sampled at edge N: `running` = 1 after edge N.
  - First tick is sampled at edge N+PRESCALE.
  - With PRESCALE=1, the first decrement is visible after edge N+1.
- Start-to-terminal latency from `load_value` = V: terminal is reached V×PRESCALE edges after the `start` edge.
- `expired` rises on the same edge where `counter` becomes 0, or becomes the reload value.
- When `running` falls at terminal, it falls on that same edge.
- Reset assertion mid-count: outputs take their reset values immediately, with no clock needed. After deassertion the block is in IDLE and needs `load` plus `start`.

## Configuration

- Macro: `DOWN_COUNTER_TIMER_AUTO_RELOAD_EN`.
- Defined, terminal tick behaviour:
  - `counter` takes the reload register value.
  - FSM stays in RUN; the prescaler continues.
  - `expired` pulses.
  - Result is a periodic timer with period V×PRESCALE cycles.
- Undefined, terminal tick behaviour:
  - `counter` = 0 and the FSM goes to DONE.
  - `running` = 0 and `expired` pulses.
  - Result is a one-shot timer.

## Test plan

- Reset: hold `reset`=0 mid-RUN with `counter`=7, then release. Required: immediately `counter`=0, `running`=0, `expired`=0, `zero`=1. A `start` with no `load` is ignored.
- One-shot (macro undefined), WIDTH=4, PRESCALE=1: `load` 5, then `start`. Required:
  - `counter` sequence 5,4,3,2,1,0 on consecutive edges.
  - `expired`=1 for one cycle at the first 0; `running`=0 on the same edge.
  - A later `start` reloads 5 and runs again.
- Prescale, PRESCALE=3: `load` 2, then `start`. Required: `counter` changes to 1 three edges after `start` and to 0 three edges later; 6 cycles total.
- Stop/resume and priority:
  - `stop` at `counter`=3 holds 3 for 10 cycles; `start` resumes at 3→2 after PRESCALE edges.
  - `load`+`stop`+`start` in the same cycle with `load_value`=9 gives `counter`=9 and IDLE.
- Auto-reload (macro defined): `load` 3, then `start`, PRESCALE=1. Required:
  - `counter` sequence 3,2,1,3,2,1,3…
  - `expired` pulses every 3 cycles; `running` stays 1.
- Boundary, WIDTH=4: `load` 0, then `start`: stays IDLE, no `expired`. `load` 15, then `start`: decrements 15→0 with no wrap.
